dac_stream_aligner: RTL and testbench

Downstream stage of `output_scaler`: it consumes the 256-bit DAC word (16 × 16-bit samples, sample 0 in bits 15:0) produced every clk and drives the RFSoC DAC AXI-Stream input. It applies a GPIO-programmable coarse delay of whole words and a fine delay of whole samples across word boundaries, so that each channel's pulses can be time-aligned. It also gates the stream and counts cycles that the DAC did not accept.

---
 rtl/dac_stream_aligner.sv | 53 +++++
 tb/tb_dac_stream_aligner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_aligner.sv
// dac_stream_aligner: GPIO-programmed coarse (word) and fine (sample) delay of a 16-sample DAC stream with drop counting
module dac_stream_aligner #(
  parameter logic [15:0] REG_BASE = 16'h0200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  gpio_in,
  input  logic [255:0] word_in,
  input  logic         word_valid_in,
  output logic [255:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [15:0]  drop_count
);
  logic [2:0] ws;
  logic [3:0] c, f;
  logic en, rise, clr, unused;
  logic [15:0] off;
  logic [15:0][255:0] d;
  logic [255:0] sel, sel_prev, fine;
  logic [511:0] cat;
  assign unused = ^{gpio_in[31:25], gpio_in[23:20]};
  assign rise = ws[1] & ~ws[2];
  assign off = gpio_in[15:0] - REG_BASE;
  assign clr = rise && off == 16'd2 && gpio_in[17];
  assign sel = d[c];
  assign cat = {sel, sel_prev};
  // shifting the pair right by 16-F samples pulls the previous word's tail into samples 0..F-1
  assign fine = 256'(cat >> {5'(5'd16 - {1'b0, f}), 4'b0});
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ws <= '0;
      c <= '0;
      f <= '0;
      en <= 1'b0;
      d <= '0;
      sel_prev <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      drop_count <= '0;
    end else begin
      ws <= {ws[1:0], gpio_in[24]};
      if (rise && off == 16'd0) c <= gpio_in[19:16];
      if (rise && off == 16'd1) f <= gpio_in[19:16];
      if (rise && off == 16'd2) en <= gpio_in[16];
      d <= {d[14:0], word_valid_in && en ? word_in : 256'd0};
      sel_prev <= sel;
      m_axis_tvalid <= en;
      m_axis_tdata <= en ? fine : '0;
      drop_count <= clr ? 16'd0 :
                    (m_axis_tvalid && !m_axis_tready && drop_count != 16'hffff) ? drop_count + 16'd1 : drop_count;
    end
endmodule

// File: tb/tb_dac_stream_aligner.sv
// tb_dac_stream_aligner: table vectors, directed corner cases and a sample-timeline model for random streams
module tb_dac_stream_aligner;
  localparam logic [15:0] BASE = 16'h0200;
  localparam logic [255:0] W = 256'h0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [255:0] word_in = '0;
  logic word_valid_in = 1'b0;
  logic [255:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [15:0] drop_count;
  int n_cmp = 0, n_bad = 0;
  logic [255:0] q[$];
  typedef struct {
    logic [3:0] c, f;
    logic v;
    logic [255:0] w1, w2, e1, e2;
  } vec_t;
  vec_t tv[6];

  dac_stream_aligner #(.REG_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .word_in(word_in), .word_valid_in(word_valid_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] o, input logic [7:0] data);
    gpio_in = {7'b0, 1'b0, data, BASE + o};
    repeat (2) @(posedge clk);
    gpio_in[24] = 1'b1;
    repeat (5) @(posedge clk);
    gpio_in[24] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // sample idx of the flattened input timeline recorded since the phase started
  function automatic logic [15:0] samp(int idx);
    logic [255:0] w;
    w = q[idx / 16];
    return w[16*(idx % 16) +: 16];
  endfunction

  initial begin
    logic [255:0] e;
    logic [255:0] got [4];
    int nv, c, f, j;
    tv[0] = '{4'd0, 4'd0, 1'b1, W, 256'd0, W, 256'd0};
    tv[1] = '{4'd0, 4'd0, 1'b0, W, W, 256'd0, 256'd0};
    tv[2] = '{4'd3, 4'd0, 1'b1, W, 256'd0, W, 256'd0};
    tv[3] = '{4'd15, 4'd0, 1'b1, W, 256'd0, W, 256'd0};
    tv[4] = '{4'd0, 4'd4, 1'b1, {16{16'haaaa}}, {16{16'h5555}},
              {{12{16'haaaa}}, 64'd0}, {{12{16'h5555}}, {4{16'haaaa}}}};
    tv[5] = '{4'd2, 4'd8, 1'b1, W, 256'd0,
              {128'h0008_0007_0006_0005_0004_0003_0002_0001, 128'd0},
              {128'd0, 128'h0010_000f_000e_000d_000c_000b_000a_0009}};

    for (int k = 0; k < 8; k++) begin
      word_in = rnd();
      word_valid_in = 1'b1;
      gpio_in = $urandom;
      @(negedge clk);
      check("reset_out", {m_axis_tdata, m_axis_tvalid, drop_count}, '0);
    end
    gpio_in = '0;
    word_in = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("post_reset_drop", 256'(drop_count), 256'd0);

    wr(16'd2, 8'h01);
    check("enable_tvalid", 256'(m_axis_tvalid), 256'd1);
    for (int t = 0; t < 6; t++) begin
      wr(16'd0, {4'd0, tv[t].c});
      wr(16'd1, {4'd0, tv[t].f});
      word_in = '0;
      word_valid_in = 1'b1;
      repeat (18) @(posedge clk);
      #1;
      word_in = tv[t].w1;
      word_valid_in = tv[t].v;
      @(posedge clk);
      #1;
      word_in = tv[t].w2;
      if (tv[t].c == 4'd0) check($sformatf("vec%0d_before", t), m_axis_tdata, 256'd0);
      for (int k = 1; k <= int'(tv[t].c) + 2; k++) begin
        @(posedge clk);
        #1;
        word_in = '0;
        word_valid_in = 1'b1;
        if (k == int'(tv[t].c)) check($sformatf("vec%0d_before", t), m_axis_tdata, 256'd0);
        if (k == int'(tv[t].c) + 1) check($sformatf("vec%0d_w1", t), m_axis_tdata, tv[t].e1);
        if (k == int'(tv[t].c) + 2) check($sformatf("vec%0d_w2", t), m_axis_tdata, tv[t].e2);
      end
    end

    for (int p = 0; p < 3; p++) begin
      c = $urandom_range(0, 15);
      f = $urandom_range(0, 15);
      wr(16'd0, 8'(c));
      wr(16'd1, 8'(f));
      q.delete();
      for (int k = 0; k < 80; k++) begin
        word_in = rnd();
        word_valid_in = $urandom_range(0, 3) != 0;
        m_axis_tready = $urandom_range(0, 1) != 0;
        @(posedge clk);
        q.push_back(word_valid_in ? word_in : 256'd0);
        #1;
        j = q.size() - 1;
        if (j >= 18) begin
          for (int i = 0; i < 16; i++) e[16*i +: 16] = samp(16*(j - 1 - c) + i - f);
          check($sformatf("rand_c%0d_f%0d", c, f), m_axis_tdata, e);
        end
      end
    end
    m_axis_tready = 1'b1;
    word_in = '0;

    wr(16'd2, 8'h03);
    check("clear_drop", 256'(drop_count), 256'd0);
    m_axis_tready = 1'b0;
    repeat (10) @(posedge clk);
    #1 m_axis_tready = 1'b1;
    check("drop_10", 256'(drop_count), 256'd10);
    wr(16'd3, 8'h02);
    check("bad_addr_tvalid", 256'(m_axis_tvalid), 256'd1);
    check("bad_addr_drop", 256'(drop_count), 256'd10);
    m_axis_tready = 1'b0;
    repeat (65545) @(posedge clk);
    #1;
    check("drop_saturate", 256'(drop_count), 256'hffff);
    gpio_in = {7'b0, 1'b0, 8'h03, BASE + 16'd2};
    repeat (2) @(posedge clk);
    gpio_in[24] = 1'b1;
    repeat (40) @(posedge clk);
    gpio_in[24] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("long_pulse_one_write", 256'(drop_count >= 16'd30 && drop_count <= 16'd50), 256'd1);
    check("clear_keeps_enable", 256'(m_axis_tvalid), 256'd1);
    m_axis_tready = 1'b1;

    wr(16'd2, 8'h00);
    for (int k = 0; k < 4; k++) begin
      word_in = rnd();
      word_valid_in = 1'b1;
      @(negedge clk);
      check("disabled_out", {m_axis_tdata, m_axis_tvalid}, '0);
    end
    wr(16'd0, 8'h02);
    repeat (20) @(posedge clk);
    word_in = W;
    word_valid_in = 1'b1;
    nv = 0;
    gpio_in = {7'b0, 1'b1, 8'h01, BASE + 16'd2};
    for (int k = 0; k < 40 && nv < 4; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        got[nv] = m_axis_tdata;
        nv++;
      end
    end
    gpio_in[24] = 1'b0;
    check("reenable_timeout", 256'(nv), 256'd4);
    if (nv == 4) begin
      for (int k = 0; k < 3; k++) check($sformatf("reenable_zero%0d", k), got[k], 256'd0);
      check("reenable_data", 256'(got[3] != 256'd0), 256'd1);
    end

    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_reset_out", {m_axis_tdata, m_axis_tvalid, drop_count}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", {m_axis_tdata, m_axis_tvalid}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
